// File: rtl/uart_device.sv
// uart_device -- DUT-side UART, 8N1 by default, with a small RX FIFO.
//
// Purpose:
//   Serializes bytes taken from a valid/ready source onto tx and deserializes
//   rx into an RX FIFO that is drained through a valid/ready sink. One UART
//   bit lasts CLK_SAMPLES clocks, matching the co-sim UART transactor.
//
// Parameters:
//   CLK_SAMPLES   clocks per UART bit (even, >= 2)
//   RX_FIFO_DEPTH RX FIFO entries (power of 2, >= 2)
//
// Ports:
//   clk           clock
//   rst           asynchronous active-high reset
//   rx            serial input, idle high, asynchronous to clk
//   tx            serial output, idle high (registered)
//   tx_data       byte to send
//   tx_valid      tx_data valid
//   tx_ready      transmitter idle and able to accept a byte
//   rx_data       RX FIFO head byte (registered)
//   rx_valid      RX FIFO non-empty
//   rx_ready      consumer pops the head when rx_valid
//   rx_frame_err  1-cycle pulse: stop bit sampled low
//   rx_overflow   1-cycle pulse: received byte dropped because FIFO was full
//   rx_parity_err 1-cycle pulse: parity mismatch (constant 0 without parity)
//
// Build option:
//   UART_PARITY_EN  when defined, TX appends an even-parity bit after bit 7
//                   and RX checks it (11-bit frames). Leave undefined for
//                   co-simulation with the existing 8N1 transactor.

module uart_device #(
  parameter int CLK_SAMPLES   = 4,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       tx,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_frame_err,
  output logic       rx_overflow,
  output logic       rx_parity_err
);

  localparam int              CW        = $clog2(CLK_SAMPLES + 1);
  localparam logic [CW-1:0]   BIT_CNT   = CW'(CLK_SAMPLES);
  localparam logic [CW-1:0]   BIT_LAST  = CW'(CLK_SAMPLES - 1);
  localparam logic [CW-1:0]   HALF_CNT  = CW'(CLK_SAMPLES / 2);
  localparam int              AW        = $clog2(RX_FIFO_DEPTH);
  localparam logic [AW:0]     FIFO_FULL = (AW+1)'(RX_FIFO_DEPTH);

  // ---------------------------------------------------------------------
  // TX: serializer FSM
  // ---------------------------------------------------------------------
  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PAR,
    TX_STOP
  } tx_state_t;

  tx_state_t       r_tx_state;
  logic            r_tx;
  logic            r_tx_ready;
  logic [CW-1:0]   r_tx_cnt;
  logic [2:0]      r_tx_bit;
  logic [7:0]      r_tx_shift;
`ifdef UART_PARITY_EN
  logic            r_tx_par;
`endif

  logic            w_tx_accept;
  logic            w_tx_bit_end;

  // tx_ready is only ever high in TX_IDLE, so the handshake doubles as the
  // "idle and requested" condition.
  assign w_tx_accept  = tx_valid & r_tx_ready;
  // r_tx_cnt counts down from CLK_SAMPLES-1; zero marks the last cycle of a bit.
  assign w_tx_bit_end = (r_tx_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_state <= TX_IDLE;
      r_tx       <= 1'b1;
      r_tx_ready <= 1'b1;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          if (w_tx_accept) begin
            r_tx_state <= TX_START;
            r_tx       <= 1'b0;
            r_tx_ready <= 1'b0;
            r_tx_cnt   <= BIT_LAST;
          end
        end
        TX_START: begin
          if (w_tx_bit_end) begin
            r_tx_state <= TX_DATA;
            r_tx       <= r_tx_shift[0];
            r_tx_cnt   <= BIT_LAST;
            r_tx_bit   <= '0;
          end else begin
            r_tx_cnt <= r_tx_cnt - 1'b1;
          end
        end
        TX_DATA: begin
          if (w_tx_bit_end) begin
            r_tx_cnt <= BIT_LAST;
            if (r_tx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
              r_tx_state <= TX_PAR;
              r_tx       <= r_tx_par;
`else
              r_tx_state <= TX_STOP;
              r_tx       <= 1'b1;
`endif
            end else begin
              r_tx_bit <= r_tx_bit + 3'd1;
              // The shifter advances on this same edge, so bit 1 is next.
              r_tx     <= r_tx_shift[1];
            end
          end else begin
            r_tx_cnt <= r_tx_cnt - 1'b1;
          end
        end
        TX_PAR: begin
          if (w_tx_bit_end) begin
            r_tx_state <= TX_STOP;
            r_tx       <= 1'b1;
            r_tx_cnt   <= BIT_LAST;
          end else begin
            r_tx_cnt <= r_tx_cnt - 1'b1;
          end
        end
        TX_STOP: begin
          if (w_tx_bit_end) begin
            r_tx_state <= TX_IDLE;
            r_tx_ready <= 1'b1;
          end else begin
            r_tx_cnt <= r_tx_cnt - 1'b1;
          end
        end
        default: begin
          r_tx_state <= TX_IDLE;
          r_tx       <= 1'b1;
          r_tx_ready <= 1'b1;
        end
      endcase
    end
  end

  // Data-only shifter: loaded on the handshake, shifted at each data-bit end.
  always_ff @(posedge clk) begin
    if (w_tx_accept) begin
      r_tx_shift <= tx_data;
`ifdef UART_PARITY_EN
      r_tx_par   <= ^tx_data;
`endif
    end else if (r_tx_state == TX_DATA && w_tx_bit_end) begin
      r_tx_shift <= {1'b0, r_tx_shift[7:1]};
    end
  end

  assign tx       = r_tx;
  assign tx_ready = r_tx_ready;

  // ---------------------------------------------------------------------
  // RX: synchronizer and edge detect
  // ---------------------------------------------------------------------
  logic r_rx_s1;
  logic r_rx_s2;
  logic r_rx_d;
  logic w_rx_fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_d  <= 1'b1;
    end else begin
      r_rx_s1 <= rx;
      r_rx_s2 <= r_rx_s1;
      r_rx_d  <= r_rx_s2;
    end
  end

  assign w_rx_fall = r_rx_d & ~r_rx_s2;

  // ---------------------------------------------------------------------
  // RX: deserializer FSM
  // ---------------------------------------------------------------------
  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PAR,
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_t;

  rx_state_t       r_rx_state;
  logic [CW-1:0]   r_rx_cnt;
  logic [2:0]      r_rx_bit;
  logic [7:0]      r_rx_shift;
  logic            r_rx_push;
  logic            r_rx_frame_err;
`ifdef UART_PARITY_EN
  logic            r_rx_par_bad;
  logic            r_rx_parity_err;
`endif
  logic            w_rx_tick;

  // r_rx_cnt holds the cycles left until the next sample; 1 means sample now.
  // Loading CLK_SAMPLES/2 on the falling edge puts every sample mid-bit.
  assign w_rx_tick = (r_rx_cnt == CW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_state     <= RX_IDLE;
      r_rx_cnt       <= '0;
      r_rx_bit       <= '0;
      r_rx_push      <= 1'b0;
      r_rx_frame_err <= 1'b0;
`ifdef UART_PARITY_EN
      r_rx_par_bad    <= 1'b0;
      r_rx_parity_err <= 1'b0;
`endif
    end else begin
      r_rx_push      <= 1'b0;
      r_rx_frame_err <= 1'b0;
`ifdef UART_PARITY_EN
      r_rx_parity_err <= 1'b0;
`endif
      case (r_rx_state)
        RX_IDLE: begin
          if (w_rx_fall) begin
            r_rx_state <= RX_START;
            r_rx_cnt   <= HALF_CNT;
          end
        end
        RX_START: begin
          if (w_rx_tick) begin
            // A start bit that is high again at mid-bit was only a glitch.
            if (r_rx_s2) begin
              r_rx_state <= RX_IDLE;
            end else begin
              r_rx_state <= RX_DATA;
              r_rx_cnt   <= BIT_CNT;
              r_rx_bit   <= '0;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt - 1'b1;
          end
        end
        RX_DATA: begin
          if (w_rx_tick) begin
            r_rx_cnt <= BIT_CNT;
            r_rx_bit <= r_rx_bit + 3'd1;
            if (r_rx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
              r_rx_state <= RX_PAR;
`else
              r_rx_state <= RX_STOP;
`endif
            end
          end else begin
            r_rx_cnt <= r_rx_cnt - 1'b1;
          end
        end
`ifdef UART_PARITY_EN
        RX_PAR: begin
          if (w_rx_tick) begin
            r_rx_state   <= RX_STOP;
            r_rx_cnt     <= BIT_CNT;
            r_rx_par_bad <= r_rx_s2 ^ (^r_rx_shift);
          end else begin
            r_rx_cnt <= r_rx_cnt - 1'b1;
          end
        end
`endif
        RX_STOP: begin
          if (w_rx_tick) begin
            // Frame error wins over parity error: one pulse per frame at most.
            if (!r_rx_s2) begin
              r_rx_frame_err <= 1'b1;
              r_rx_state     <= RX_WAIT_IDLE;
            end else begin
`ifdef UART_PARITY_EN
              if (r_rx_par_bad) begin
                r_rx_parity_err <= 1'b1;
              end else begin
                r_rx_push <= 1'b1;
              end
`else
              r_rx_push <= 1'b1;
`endif
              r_rx_state <= RX_IDLE;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt - 1'b1;
          end
        end
        RX_WAIT_IDLE: begin
          if (r_rx_s2) begin
            r_rx_state <= RX_IDLE;
          end
        end
        default: begin
          r_rx_state <= RX_IDLE;
        end
      endcase
    end
  end

  // Received byte stays stable from the last data sample until the push.
  always_ff @(posedge clk) begin
    if (r_rx_state == RX_DATA && w_rx_tick) begin
      r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
    end
  end

  // ---------------------------------------------------------------------
  // RX FIFO with registered head
  // ---------------------------------------------------------------------
  logic [7:0]      r_mem [RX_FIFO_DEPTH];
  logic [AW:0]     r_wr;
  logic [AW:0]     r_rd;
  logic            r_rx_valid;
  logic [7:0]      r_rx_data;
  logic            r_rx_overflow;

  logic [AW:0]     w_count;
  logic            w_full;
  logic            w_pop;
  logic            w_push_ok;
  logic [AW:0]     w_rd_nxt;
  logic [AW:0]     w_wr_nxt;
  logic            w_nonempty_nxt;
  logic [7:0]      w_head_nxt;

  assign w_count        = r_wr - r_rd;
  assign w_full         = (w_count == FIFO_FULL);
  assign w_pop          = r_rx_valid & rx_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push_ok      = r_rx_push & (~w_full | w_pop);
  assign w_rd_nxt       = r_rd + {{AW{1'b0}}, w_pop};
  assign w_wr_nxt       = r_wr + {{AW{1'b0}}, w_push_ok};
  assign w_nonempty_nxt = (w_wr_nxt != w_rd_nxt);
  // When the incoming byte lands at the new head slot it is not yet in r_mem,
  // so bypass it straight into the head register.
  assign w_head_nxt     = (w_push_ok && (r_wr == w_rd_nxt)) ? r_rx_shift
                                                            : r_mem[w_rd_nxt[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr          <= '0;
      r_rd          <= '0;
      r_rx_valid    <= 1'b0;
      r_rx_data     <= 8'h00;
      r_rx_overflow <= 1'b0;
    end else begin
      r_wr          <= w_wr_nxt;
      r_rd          <= w_rd_nxt;
      r_rx_valid    <= w_nonempty_nxt;
      r_rx_overflow <= r_rx_push & w_full & ~w_pop;
      if (w_nonempty_nxt) begin
        r_rx_data <= w_head_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr[AW-1:0]] <= r_rx_shift;
    end
  end

  assign rx_data      = r_rx_data;
  assign rx_valid     = r_rx_valid;
  assign rx_frame_err = r_rx_frame_err;
  assign rx_overflow  = r_rx_overflow;
`ifdef UART_PARITY_EN
  assign rx_parity_err = r_rx_parity_err;
`else
  assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_device.sv
// Testbench for uart_device (default 8N1 build, CLK_SAMPLES=4, depth 4).
// Stimulus processes push expected results into queues; independent monitors
// pop and compare whenever the DUT presents a TX frame, an RX byte or an
// error pulse.

module tb_uart_device;

  localparam int CS    = 4;
  localparam int DEPTH = 4;

  localparam logic [7:0] E_FRAME = 8'h46;
  localparam logic [7:0] E_OVF   = 8'h4F;
  localparam logic [7:0] E_PAR   = 8'h50;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       tx;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b1;
  logic       rx_frame_err;
  logic       rx_overflow;
  logic       rx_parity_err;

  uart_device #(.CLK_SAMPLES(CS), .RX_FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .tx           (tx),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_frame_err (rx_frame_err),
    .rx_overflow  (rx_overflow),
    .rx_parity_err(rx_parity_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // TX patterns are stored in line order: bit k is the k-th bit on the wire.
  logic [9:0] q_tx[$];
  logic [7:0] q_rx[$];
  logic [7:0] q_err[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_tx(input logic [7:0] d, input logic [9:0] pat);
    int waited;
    waited = 0;
    q_tx.push_back(pat);
    tx_data  = d;
    tx_valid = 1'b1;
    do begin
      @(negedge clk);
      waited++;
    end while (!tx_ready && waited < 200);
    if (!tx_ready) begin
      check("tx_accept_timeout", 32'(tx_ready), 32'd1);
      tx_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
  endtask

  task automatic rx_frame(input logic [7:0] d, input int stop_low);
    rx = 1'b0;
    tick(CS);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(CS);
    end
    if (stop_low > 0) begin
      rx = 1'b0;
      tick(stop_low);
    end
    rx = 1'b1;
    tick(CS);
    tick(4);
  endtask

  task automatic err_seen(input logic [7:0] code);
    if (q_err.size() == 0) check("err_unexpected", 32'(code), 32'd0);
    else                   check("err_kind", 32'(code), 32'(q_err.pop_front()));
  endtask

  // TX monitor: on each handshake, compare 10*CS samples of {tx, tx_ready}.
  initial begin
    logic [9:0] pat;
    bit         just_done;
    bit         aborted;
    just_done = 1'b0;
    forever begin
      @(negedge clk);
      if (just_done && !rst) check("tx_ready_after_frame", 32'({tx, tx_ready}), 32'b11);
      just_done = 1'b0;
      if (!rst && tx_valid && tx_ready) begin
        if (q_tx.size() == 0) begin
          check("tx_unexpected_frame", 32'(q_tx.size()), 32'd1);
        end else begin
          pat     = q_tx.pop_front();
          aborted = 1'b0;
          for (int k = 0; k < 10 && !aborted; k++) begin
            for (int j = 0; j < CS && !aborted; j++) begin
              @(negedge clk);
              if (rst) aborted = 1'b1;
              else check($sformatf("tx_bit%0d", k), 32'({tx, tx_ready}), 32'({pat[k], 1'b0}));
            end
          end
          just_done = !aborted;
        end
      end
    end
  end

  // RX monitor: every accepted byte must match the head of the queue.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && rx_valid && rx_ready) begin
        if (q_rx.size() == 0) check("rx_unexpected_byte", 32'(rx_data), 32'hFFFF_FFFF);
        else                  check("rx_data", 32'(rx_data), 32'(q_rx.pop_front()));
      end
    end
  end

  // Error-pulse monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (rx_frame_err)  err_seen(E_FRAME);
        if (rx_overflow)   err_seen(E_OVF);
        if (rx_parity_err) err_seen(E_PAR);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst = 1'b1;
    tick(3);
    @(negedge clk);
    check("rst_tx",       32'(tx),       32'd1);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data",  32'(rx_data),  32'h00);
    check("rst_errs",     32'({rx_frame_err, rx_overflow, rx_parity_err}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(3);

    // TX 0xA5 then 0x0F back to back (0x0F held valid while busy)
    send_tx(8'hA5, 10'b1101001010);
    send_tx(8'h0F, 10'b1000011110);
    tick(50);

    // Reset in the middle of a TX frame
    send_tx(8'h3C, 10'b1001111000);
    tick(15);
    #3 rst = 1'b1;
    #1;
    check("midrst_tx",       32'(tx),       32'd1);
    check("midrst_tx_ready", 32'(tx_ready), 32'd1);
    check("midrst_rx_valid", 32'(rx_valid), 32'd0);
    tick(3);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_after_rst", 32'({tx, tx_ready, rx_valid}), 32'b110);
    end
    @(posedge clk);
    #1;

    // RX 0x3C
    q_rx.push_back(8'h3C);
    rx_frame(8'h3C, 0);
    tick(4);

    // One-cycle glitch, then 0x55
    rx = 1'b0;
    tick(1);
    rx = 1'b1;
    tick(8);
    q_rx.push_back(8'h55);
    rx_frame(8'h55, 0);

    // Frame error on 0x81 (stop low 8 cycles), then 0x7E
    q_err.push_back(E_FRAME);
    rx_frame(8'h81, 8);
    q_rx.push_back(8'h7E);
    rx_frame(8'h7E, 0);

    // Overflow: five frames into a depth-4 FIFO with no consumer
    rx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i <= DEPTH) q_rx.push_back(8'(i));
      else            q_err.push_back(E_OVF);
      rx_frame(8'(i), 0);
    end
    @(negedge clk);
    check("ovf_rx_valid", 32'(rx_valid), 32'd1);
    check("ovf_head",     32'(rx_data),  32'h01);
    @(posedge clk);
    #1;
    rx_ready = 1'b1;
    tick(10);
    @(negedge clk);
    check("drained_rx_valid", 32'(rx_valid), 32'd0);
    @(posedge clk);
    #1;
    tick(2);

    check("tx_queue_empty",  32'(q_tx.size()),  32'd0);
    check("rx_queue_empty",  32'(q_rx.size()),  32'd0);
    check("err_queue_empty", 32'(q_err.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
